// File: rtl/dp_dr_sel_pkg.sv
// Shared constants for the debug data-register selector: IR codes, channel
// indices and the selection record for the default three-channel build.
package dp_dr_sel_pkg;

  localparam int unsigned IrWDefault   = 5;
  localparam int unsigned NumChDefault = 3;

  localparam logic [IrWDefault-1:0] IrIdcode = 5'h01;
  localparam logic [IrWDefault-1:0] IrDtmcs  = 5'h10;
  localparam logic [IrWDefault-1:0] IrDmi    = 5'h11;
  localparam logic [IrWDefault-1:0] IrBypass = 5'h1f;

  localparam int unsigned ChIdcode = 0;
  localparam int unsigned ChDtmcs  = 1;
  localparam int unsigned ChDmi    = 2;

  typedef struct packed {
    logic [NumChDefault-1:0] oh;
    logic                    byp;
  } dp_dr_sel_t;

endpackage

// File: rtl/dp_dr_sel_bypass_reg.sv
// One-bit BYPASS data register: cleared on capture, loads TDI on shift, only
// while the bypass path is the selected data register.
module dp_bypass_reg (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic capture_i,
  input  logic shift_i,
  input  logic tdi_i,
  output logic q_o
);

  logic q_d, q_q;

  // Capture wins over shift when both strobes are (illegally) high.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = 1'b0;
    end else if (en_i) begin
      if (capture_i) begin
        q_d = 1'b0;
      end else if (shift_i) begin
        q_d = tdi_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dp_dr_sel.sv
// Data-register selector between the TAP controller and the debug DR channels:
// IR decode into a held selection, strobe/TDO routing, bypass and scan-length counter.
module dp_dr_sel
  import dp_dr_sel_pkg::*;
#(
  parameter int unsigned                  NumCh   = 3,
  parameter int unsigned                  IrW     = 5,
  parameter logic [NumCh-1:0][IrW-1:0]    ChCodes = {IrDmi, IrDtmcs, IrIdcode},
  parameter int unsigned                  DefCh   = ChIdcode,
  parameter int unsigned                  CntW    = 8
) (
  input  logic             tck_i,
  input  logic             trst_ni,
  input  logic             tdi_i,
  input  logic [IrW-1:0]   ir_value_i,
  input  logic             update_ir_i,
  input  logic             test_logic_reset_i,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic [NumCh-1:0] ch_en_i,
  input  logic [NumCh-1:0] sdi_i,
  output logic             sdo_o,
  output logic [NumCh-1:0] capture_dr_out_o,
  output logic [NumCh-1:0] shift_dr_out_o,
  output logic [NumCh-1:0] update_dr_out_o,
  output logic [NumCh-1:0] sel_oh_o,
  output logic             bypass_sel_o,
  output logic [CntW-1:0]  shift_cnt_o,
  output logic             shift_cnt_ovf_o
);

  typedef struct packed {
    logic [NumCh-1:0] oh;
    logic             byp;
  } sel_t;

  localparam sel_t            SelRst = '{oh: NumCh'(1) << DefCh, byp: 1'b0};
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  sel_t            sel_d, sel_q, dec;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            ovf_d, ovf_q;
  logic            byp_q;
  logic [NumCh-1:0] strobe_gate;

  // Priority match: the lowest enabled channel whose code matches wins.
  always_comb begin
    dec = '{oh: '0, byp: 1'b1};
    for (int unsigned i = 0; i < NumCh; i++) begin
      if (dec.byp && ch_en_i[i] && (ir_value_i == ChCodes[i])) begin
        dec.oh[i] = 1'b1;
        dec.byp   = 1'b0;
      end
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (test_logic_reset_i) begin
      sel_d = SelRst;
    end else if (update_ir_i) begin
      sel_d = dec;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (test_logic_reset_i || capture_dr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_dr_i) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      sel_q <= SelRst;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  dp_bypass_reg u_bypass_reg (
    .clk_i     (tck_i),
    .rst_ni    (trst_ni),
    .clr_i     (test_logic_reset_i),
    .en_i      (sel_q.byp),
    .capture_i (capture_dr_i),
    .shift_i   (shift_dr_i),
    .tdi_i     (tdi_i),
    .q_o       (byp_q)
  );

  // Strobes are suppressed while trst is asserted so an aborted scan emits nothing.
  assign strobe_gate      = sel_q.oh & {NumCh{trst_ni}};
  assign capture_dr_out_o = {NumCh{capture_dr_i}} & strobe_gate;
  assign shift_dr_out_o   = {NumCh{shift_dr_i}} & strobe_gate;
  assign update_dr_out_o  = {NumCh{update_dr_i}} & strobe_gate;

  assign sdo_o           = sel_q.byp ? byp_q : |(sdi_i & sel_q.oh);
  assign sel_oh_o        = sel_q.oh;
  assign bypass_sel_o    = sel_q.byp;
  assign shift_cnt_o     = cnt_q;
  assign shift_cnt_ovf_o = ovf_q;

endmodule

// File: tb/tb_dp_dr_sel.sv
// Randomised self-checking bench for dp_dr_sel against a behavioural model of
// the selector, bypass bit and scan-length counters (8-bit and 4-bit builds).
module tb_dp_dr_sel;

  logic       tck = 1'b0;
  logic       trst_n = 1'b1;
  logic       tdi = 1'b0;
  logic [4:0] ir_value = '0;
  logic       update_ir = 1'b0, tlr = 1'b0;
  logic       capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
  logic [2:0] ch_en = 3'b111, sdi = '0;

  logic       sdo, bypass_sel, ovf8;
  logic [2:0] cap_out, sh_out, up_out, sel_oh;
  logic [7:0] cnt8;
  logic       sdo4, bypass_sel4, ovf4;
  logic [2:0] cap_out4, sh_out4, up_out4, sel_oh4;
  logic [3:0] cnt4;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  dp_dr_sel dut (
    .tck_i(tck), .trst_ni(trst_n), .tdi_i(tdi), .ir_value_i(ir_value),
    .update_ir_i(update_ir), .test_logic_reset_i(tlr), .capture_dr_i(capture_dr),
    .shift_dr_i(shift_dr), .update_dr_i(update_dr), .ch_en_i(ch_en), .sdi_i(sdi),
    .sdo_o(sdo), .capture_dr_out_o(cap_out), .shift_dr_out_o(sh_out),
    .update_dr_out_o(up_out), .sel_oh_o(sel_oh), .bypass_sel_o(bypass_sel),
    .shift_cnt_o(cnt8), .shift_cnt_ovf_o(ovf8)
  );

  dp_dr_sel #(.CntW(4)) dut4 (
    .tck_i(tck), .trst_ni(trst_n), .tdi_i(tdi), .ir_value_i(ir_value),
    .update_ir_i(update_ir), .test_logic_reset_i(tlr), .capture_dr_i(capture_dr),
    .shift_dr_i(shift_dr), .update_dr_i(update_dr), .ch_en_i(ch_en), .sdi_i(sdi),
    .sdo_o(sdo4), .capture_dr_out_o(cap_out4), .shift_dr_out_o(sh_out4),
    .update_dr_out_o(up_out4), .sel_oh_o(sel_oh4), .bypass_sel_o(bypass_sel4),
    .shift_cnt_o(cnt4), .shift_cnt_ovf_o(ovf4)
  );

  // ---------------- reference model ----------------
  int codes [3] = '{32'h01, 32'h10, 32'h11};
  int m_sel = 0;      // selected channel index, -1 means bypass
  bit m_byp = 1'b0;
  int m_cnt8 = 0, m_cnt4 = 0;
  bit m_ovf8 = 1'b0, m_ovf4 = 1'b0;

  function automatic int decode(input logic [4:0] ir, input logic [2:0] en);
    for (int i = 0; i < 3; i++) begin
      if (en[i] && (int'(ir) == codes[i])) return i;
    end
    return -1;
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n || (tlr && tck)) begin
      m_sel <= 0; m_byp <= 1'b0;
      m_cnt8 <= 0; m_cnt4 <= 0; m_ovf8 <= 1'b0; m_ovf4 <= 1'b0;
    end else begin
      if (m_sel < 0 && capture_dr) m_byp <= 1'b0;
      else if (m_sel < 0 && shift_dr) m_byp <= tdi;
      if (capture_dr) begin
        m_cnt8 <= 0; m_cnt4 <= 0; m_ovf8 <= 1'b0; m_ovf4 <= 1'b0;
      end else if (shift_dr) begin
        if (m_cnt8 == 255) m_ovf8 <= 1'b1; else m_cnt8 <= m_cnt8 + 1;
        if (m_cnt4 == 15) m_ovf4 <= 1'b1; else m_cnt4 <= m_cnt4 + 1;
      end
      if (update_ir) m_sel <= decode(ir_value, ch_en);
    end
  end

  function automatic logic [33:0] exp_vec();
    logic [2:0] oh, g;
    logic       b, s;
    oh = (m_sel >= 0) ? 3'(1 << m_sel) : 3'b000;
    b  = (m_sel < 0);
    g  = trst_n ? oh : 3'b000;
    s  = b ? m_byp : sdi[m_sel];
    return {oh, b, capture_dr ? g : 3'b0, shift_dr ? g : 3'b0, update_dr ? g : 3'b0, s,
            8'(m_cnt8), m_ovf8, 4'(m_cnt4), m_ovf4, 6'b0};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {sel_oh, bypass_sel, cap_out, sh_out, up_out, sdo, cnt8, ovf8, cnt4, ovf4, 6'b0};
  endfunction

  // Drive one cycle's TAP inputs just after the falling edge, settle, then return.
  task automatic step(input logic cap, input logic sh, input logic upd, input logic uir,
                      input logic tl, input logic [4:0] ir, input logic [2:0] en,
                      input logic t);
    @(negedge tck);
    capture_dr = cap; shift_dr = sh; update_dr = upd; update_ir = uir; tlr = tl;
    ir_value = ir; ch_en = en; tdi = t; sdi = 3'($urandom);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 trst_n = 1'b0;
    #1;
    total++;
    if (obs_vec() !== exp_vec() || sel_oh !== 3'b001 || bypass_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset: got %h sel=%b want %h sel=001", obs_vec(), sel_oh, exp_vec());
    end
    @(negedge tck);
    trst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (sh_out !== 3'b001 || sdo !== sdi[0] || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL reset_shift: sh_out=%b sdo=%b want 001 sdo=%b", sh_out, sdo, sdi[0]);
    end
  endtask

  task automatic test_sel_dmi();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h11, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (sel_oh !== 3'b100 || cap_out !== 3'b100 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL sel_dmi: sel=%b cap=%b want 100/100", sel_oh, cap_out);
    end
    for (int i = 0; i < 41; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'($urandom));
      total++;
      if (sh_out !== 3'b100 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL dmi_shift[%0d]: got %h sh=%b want %h", i, obs_vec(), sh_out, exp_vec());
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (cnt8 !== 8'd41 || up_out !== 3'b100 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL dmi_count: cnt=%0d up=%b want 41/100", cnt8, up_out);
    end
  endtask

  task automatic test_bypass();
    logic [2:0] tdis = 3'b101;
    logic [2:0] sdos = 3'b010;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h1f, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (bypass_sel !== 1'b1 || sel_oh !== 3'b000 || cap_out !== 3'b000) begin
      bad++;
      $display("FAIL bypass_sel: byp=%b sel=%b cap=%b want 1/000/000", bypass_sel, sel_oh,
               cap_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, tdis[2-i]);
      total++;
      if (sdo !== sdos[2-i] || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL bypass_sdo[%0d]: got %b want %b", i, sdo, sdos[2-i]);
      end
    end
  endtask

  task automatic test_ch_en_sample();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h10, 3'b101, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h10, 3'b111, 1'b0);
      total++;
      if (bypass_sel !== 1'b1 || sel_oh !== 3'b000 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL ch_en_sample[%0d]: byp=%b sel=%b want 1/000", i, bypass_sel, sel_oh);
      end
    end
  endtask

  task automatic test_cnt_sat();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (cnt4 !== 4'd15 || ovf4 !== 1'b1 || cnt8 !== 8'd20 || ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL cnt_sat: cnt4=%0d ovf4=%b cnt8=%0d ovf8=%b want 15/1/20/0", cnt4, ovf4,
               cnt8, ovf8);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (cnt4 !== 4'd0 || ovf4 !== 1'b0 || cnt8 !== 8'd0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL cnt_clear: cnt4=%0d ovf4=%b cnt8=%0d want 0/0/0", cnt4, ovf4, cnt8);
    end
  endtask

  task automatic test_tlr();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h1f, 3'b111, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h11, 3'b111, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    total++;
    if (sel_oh !== 3'b001 || bypass_sel !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL tlr_priority: sel=%b byp=%b want 001/0", sel_oh, bypass_sel);
    end
  endtask

  task automatic test_trst_mid();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h11, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b1);
    trst_n = 1'b0;
    #1;
    total++;
    if (sel_oh !== 3'b001 || sh_out !== 3'b000 || cnt8 !== 8'd0 || bypass_sel !== 1'b0 ||
        obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL trst_mid: sel=%b sh=%b cnt=%0d want 001/000/0", sel_oh, sh_out, cnt8);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 3'b111, 1'b0);
    trst_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic [4:0] ir;
    logic       cap, sh;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ir = 5'h01;
        1:       ir = 5'h10;
        2:       ir = 5'h11;
        default: ir = 5'($urandom);
      endcase
      cap = ($urandom_range(0, 7) == 0);
      sh  = ($urandom_range(0, 3) != 0);
      step(cap, sh, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 40) == 0), ir, 3'($urandom), 1'($urandom));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sel_dmi();
    test_bypass();
    test_ch_en_sample();
    test_cnt_sat();
    test_tlr();
    test_trst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_dr_sel.md
Name: dp_dr_sel

Overview:
- Parametrised data-register selector between the TAP controller and N_CH debug data registers (IDCODE, DTMCS, DMI, ...).
- Decodes the IR value, holds the selection in a register, and routes TDO and the capture/shift/update enables to the selected channel.
- Contains an internal 1-bit BYPASS register, used for unmatched or disabled instructions.
- Includes a shift-length counter with sticky overflow, so the debug module can check DR scan length.

Parameters:
- N_CH, 3, number of external data-register channels.
- IR_W, 5, instruction register width.
- CH_CODES, {5'h11,5'h10,5'h01}, packed array [N_CH][IR_W]: IR code per channel (ch0=IDCODE 0x01, ch1=DTMCS 0x10, ch2=DMI 0x11).
- DEF_CH, 0, channel selected after reset/test_logic_reset (IDCODE).
- CNT_W, 8, shift counter width.

Ports:
- tck  in  1  TAP clock, all state on rising edge.
- trst_n  in  1  asynchronous active-low reset.
- tdi  in  1  serial data in, for internal bypass.
- ir_value  in  IR_W  current IR contents.
- update_ir  in  1  TAP Update-IR state strobe.
- test_logic_reset  in  1  TAP Test-Logic-Reset state.
- capture_dr  in  1  TAP Capture-DR state.
- shift_dr  in  1  TAP Shift-DR state.
- update_dr  in  1  TAP Update-DR state.
- ch_en  in  N_CH  runtime channel enable mask.
- sdi  in  N_CH  serial outputs of channel registers.
- sdo  out  1  serial output toward TDO retiming.
- capture_dr_out  out  N_CH  per-channel capture enable.
- shift_dr_out  out  N_CH  per-channel shift enable.
- update_dr_out  out  N_CH  per-channel update enable.
- sel_oh  out  N_CH  registered one-hot selection.
- bypass_sel  out  1  internal bypass selected.
- shift_cnt  out  CNT_W  Shift-DR cycles since last Capture-DR.
- shift_cnt_ovf  out  1  sticky counter saturation flag.

Behaviour:
- **Reset** (trst_n=0, asynchronous):
  - sel_oh = one-hot(DEF_CH), bypass_sel=0.
  - Bypass flop = 0, shift_cnt=0, shift_cnt_ovf=0.
- **test_logic_reset=1** on a rising edge: same values as reset, applied synchronously. Takes priority over update_ir.
- **Selection update** (update_ir=1):
  - On the rising edge, decode ir_value against CH_CODES.
  - Lowest matching index i with ch_en[i]=1 wins: sel_oh=one-hot(i), bypass_sel=0.
  - No enabled match: sel_oh=0, bypass_sel=1.
  - ch_en is sampled only at update_ir; later changes have no effect until the next update_ir.
- **Selection timing**: the new selection is visible from the cycle after the update_ir edge. sel_oh and bypass_sel are mutually exclusive and never both zero.
- **Routing** (combinational from the selection register):
  - X_out[i] = X & sel_oh[i] for X in {capture_dr, shift_dr, update_dr}; unselected channels get 0.
  - sdo = sdi[i] for the selected channel, or the bypass flop when bypass_sel=1.
- **Bypass register**:
  - Active only when bypass_sel=1.
  - capture_dr loads 0; shift_dr loads tdi; otherwise hold.
- **Shift counter**:
  - capture_dr clears shift_cnt to 0 and clears shift_cnt_ovf.
  - Each rising edge with shift_dr=1 increments shift_cnt, saturating at 2^CNT_W-1.
  - An increment attempt at max sets shift_cnt_ovf; it stays set until the next capture_dr.
  - The counter counts regardless of the selected channel.
- **Simultaneous strobes**: capture_dr and shift_dr both high (illegal) gives capture priority for both the counter and bypass.
- **Mid-scan events**:
  - An update_ir during shift_dr (illegal TAP sequence) is still applied; routing switches the next cycle.
  - trst_n asserted mid-scan aborts it immediately; no channel strobe is emitted after reset.
- **Width rules**: N_CH>=1. A one-hot index is encoded as $clog2(N_CH) internally where needed.

Decomposition:
- dp_constants package holds:
  - IR code constants (IDCODE, DTMCS, DMI, BYPASS).
  - Channel index constants.
  - The dp_dr_sel_t typedef (struct: logic [N_CH-1:0] oh, logic byp).
- One sub-module, dp_bypass_reg: the 1-bit bypass flop with capture/shift enables.
- The decode is a for-loop priority match inside dp_dr_sel.

Test Plan:
- Reset → sel_oh=3'b001, bypass_sel=0; shift_dr=1 for 1 cycle → shift_dr_out=3'b001, sdo tracks sdi[0].
- update_ir with ir_value=5'h11, ch_en=3'b111 → next cycle sel_oh=3'b100; 41 shift cycles after capture → shift_cnt=41, only shift_dr_out[2] pulses.
- update_ir with ir_value=5'h1F → bypass_sel=1, sel_oh=0; capture, then shift tdi=1,0,1 → sdo=0,1,0 (one-cycle delay).
- ch_en=3'b101 and ir_value=5'h10 at update_ir → bypass_sel=1; then ch_en→3'b111 with no update_ir → bypass_sel stays 1.
- CNT_W=4, capture then 20 shift cycles → shift_cnt=15, shift_cnt_ovf=1; next capture_dr → 0/0.
- test_logic_reset and update_ir(5'h11) on the same edge → sel_oh=3'b001; trst_n pulse mid-shift → all outputs at reset values immediately.
